// File: rtl/rb_stream_controller.sv
// -----------------------------------------------------------------------------
// rb_stream_controller
//
// Sequences one image frame through a bank of row buffers. Pixels are fetched
// from external memory one per cycle; returning data is written into the row
// buffers. Once RBs rows are resident, each new write slot also reads the old
// pixel at that address (read-before-write), so a full window column comes out
// per read. After the last write, DRAIN reads out the final row.
//
// Optional feature: define RB_CTRL_ABORT_EN to add an `abort` input that
// cancels a running frame (back to IDLE, delay line cleared, no done pulse).
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   start           in   frame-start request, honoured in IDLE only
//   abort           in   (RB_CTRL_ABORT_EN only) cancel the current frame
//   en_e_mem_addr   out  fetch one pixel / advance external-memory address
//   en_w_bram_addr  out  returning pixel data; advance row-buffer write address
//   en_r_bram_addr  out  advance row-buffer read address
//   win_valid       out  window column on the row-buffer read port is valid
//   out_row         out  window row index (qualified by win_valid)
//   out_col         out  window column index (qualified by win_valid)
//   busy            out  state is not IDLE
//   done            out  single-cycle end-of-frame pulse
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module rb_stream_controller #(
    parameter int RB_DEPTH = 512,
    parameter int RBs      = 4,
    parameter int IMG_ROWS = 512,
    parameter int EMEM_LAT = 1,
    localparam int ROW_W   = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1,
    localparam int COL_W   = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef RB_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             en_e_mem_addr,
    output logic             en_w_bram_addr,
    output logic             en_r_bram_addr,
    output logic             win_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
    output logic             done
);

    localparam int TOTAL_PIX = IMG_ROWS * RB_DEPTH;
    localparam int CNT_W     = $clog2(TOTAL_PIX + 1);
    localparam int DRN_W     = $clog2(RB_DEPTH + 1);

    localparam logic [CNT_W-1:0] TOTAL_C   = CNT_W'(TOTAL_PIX);
    localparam logic [CNT_W-1:0] PRIME_C   = CNT_W'(RBs * RB_DEPTH);
    localparam logic [DRN_W-1:0] DRAIN_C   = DRN_W'(RB_DEPTH);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(RB_DEPTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_ROWS - 1);
    // With every row primed there is nothing left to fetch in STREAM.
    localparam bit               HAS_STREAM = (RBs != IMG_ROWS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [DRN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [EMEM_LAT-1:0] dly_q, dly_d;
    logic               rd_arm_q, rd_arm_d;
    logic               en_e_q, en_e_d;
    logic               en_r_q, en_r_d;
    logic               win_valid_q, win_valid_d;
    logic [ROW_W-1:0]   out_row_q, out_row_d;
    logic [COL_W-1:0]   out_col_q, out_col_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               en_w;
    logic               last_write;

    // The write strobe is the tail of the fetch delay line.
    assign en_w = dly_q[EMEM_LAT-1];

    always_comb begin
        state_d     = state_q;
        fetch_cnt_d = fetch_cnt_q + CNT_W'(en_e_q);
        wr_cnt_d    = wr_cnt_q + CNT_W'(en_w);
        drain_cnt_d = drain_cnt_q + DRN_W'(en_r_q && (state_q == S_DRAIN));
        dly_d       = (dly_q << 1) | EMEM_LAT'(en_e_q);
        // Arm reads once the RBs-th row has been fully written; every later
        // write slot doubles as a read slot.
        rd_arm_d    = rd_arm_q | (en_w && (wr_cnt_d == PRIME_C));
        last_write  = en_w && (wr_cnt_d == TOTAL_C);
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;

        if (win_valid_q) begin
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
            end else begin
                out_col_d = out_col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_PRIME;
                    fetch_cnt_d = '0;
                    wr_cnt_d    = '0;
                    drain_cnt_d = '0;
                    rd_arm_d    = 1'b0;
                end
            end
            S_PRIME: begin
                if (last_write) begin
                    state_d = S_DRAIN;
                end else if (HAS_STREAM && (fetch_cnt_d == PRIME_C)) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_write) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // drain_cnt_q hits RB_DEPTH in the cycle carrying the last
                // win_valid, i.e. one cycle after the last read.
                if (drain_cnt_q == DRAIN_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef RB_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            dly_d   = '0;
        end
`endif

        if (state_d == S_IDLE) begin
            out_row_d = '0;
            out_col_d = '0;
        end

        en_e_d      = ((state_d == S_PRIME) || (state_d == S_STREAM)) &&
                      (fetch_cnt_d != TOTAL_C);
        en_r_d      = (dly_d[EMEM_LAT-1] && rd_arm_d) ||
                      ((state_d == S_DRAIN) && (drain_cnt_d != DRAIN_C));
        win_valid_d = en_r_q && (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            fetch_cnt_q <= '0;
            wr_cnt_q    <= '0;
            drain_cnt_q <= '0;
            dly_q       <= '0;
            rd_arm_q    <= 1'b0;
            en_e_q      <= 1'b0;
            en_r_q      <= 1'b0;
            win_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_cnt_q <= fetch_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            dly_q       <= dly_d;
            rd_arm_q    <= rd_arm_d;
            en_e_q      <= en_e_d;
            en_r_q      <= en_r_d;
            win_valid_q <= win_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign en_e_mem_addr  = en_e_q;
    assign en_w_bram_addr = en_w;
    assign en_r_bram_addr = en_r_q;
    assign win_valid      = win_valid_q;
    assign out_row        = out_row_q;
    assign out_col        = out_col_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_rb_stream_controller.sv
// -----------------------------------------------------------------------------
// tb_rb_stream_controller
//
// Two instances of rb_stream_controller on a small geometry (8 pixels/row,
// 4 rows, 1-cycle memory latency): u_dut1 with 2 row buffers, u_dut2 with all
// 4 rows buffered. Expected per-cycle outputs come from interval formulas of
// the frame timeline and are queued when a frame is launched, then popped and
// compared one cycle at a time (1 time unit after each rising edge).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rb_stream_controller;

    localparam int D     = 8;
    localparam int ROWS  = 4;
    localparam int LAT   = 1;
    localparam int ROW_W = 2;
    localparam int COL_W = 3;
    localparam int FRAME = 44;   // start-sample to next possible start-sample

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             en_e;
        logic             en_w;
        logic             en_r;
        logic             wv;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
`ifdef RB_CTRL_ABORT_EN
    logic abort1 = 1'b0;
    logic abort2 = 1'b0;
`endif

    logic             e1, w1, r1, v1, busy1, done1;
    logic             e2, w2, r2, v2, busy2, done2;
    logic [ROW_W-1:0] row1, row2;
    logic [COL_W-1:0] col1, col2;

    int   n_vec = 0;
    int   n_err = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rb_stream_controller #(.RB_DEPTH(D), .RBs(2), .IMG_ROWS(ROWS), .EMEM_LAT(LAT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef RB_CTRL_ABORT_EN
        .abort(abort1),
`endif
        .en_e_mem_addr(e1), .en_w_bram_addr(w1), .en_r_bram_addr(r1),
        .win_valid(v1), .out_row(row1), .out_col(col1), .busy(busy1), .done(done1)
    );

    rb_stream_controller #(.RB_DEPTH(D), .RBs(4), .IMG_ROWS(ROWS), .EMEM_LAT(LAT)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef RB_CTRL_ABORT_EN
        .abort(abort2),
`endif
        .en_e_mem_addr(e2), .en_w_bram_addr(w2), .en_r_bram_addr(r2),
        .win_valid(v2), .out_row(row2), .out_col(col2), .busy(busy2), .done(done2)
    );

    // Expected outputs in cycle k (k = 1 is the cycle after the start sample)
    // for a frame with r row buffers.
    function automatic vec_t model(input int r, input int k);
        vec_t e;
        int   f;
        int   rs;
        int   re;
        int   n;
        f  = ROWS * D;
        rs = r * D + 1 + LAT;     // first read: first write of row r
        re = f + LAT + D;         // last drain read
        e.en_e = (k >= 1) && (k <= f);
        e.en_w = (k >= 1 + LAT) && (k <= f + LAT);
        e.en_r = (k >= rs) && (k <= re);
        e.wv   = (k >= rs + 1) && (k <= re + 1);
        e.busy = (k >= 1) && (k <= re + 2);
        e.done = (k == re + 2);
        n      = k - (rs + 1);
        if (e.wv) begin
            e.row = ROW_W'(n / D);
            e.col = COL_W'(n % D);
        end else begin
            e.row = '0;
            e.col = '0;
        end
        return e;
    endfunction

    function automatic vec_t observe(input int which, input bit raw);
        vec_t o;
        if (which == 1) o = '{busy1, done1, e1, w1, r1, v1, row1, col1};
        else            o = '{busy2, done2, e2, w2, r2, v2, row2, col2};
        if (!raw && !o.wv) begin
            o.row = '0;
            o.col = '0;
        end
        return o;
    endfunction

    // Launch a frame on the chosen instance and check ncyc cycles against
    // the queued model. With hold, start stays high throughout.
    task automatic run_frames(input int which, input int r, input int ncyc,
                              input bit hold, input string name);
        vec_t o;
        vec_t e;
        for (int k = 1; k <= ncyc; k++) exp_q.push_back(model(r, ((k - 1) % FRAME) + 1));
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start1 = 1'b0;
            start2 = 1'b0;
        end
        for (int k = 1; k <= ncyc; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            e = exp_q.pop_front();
            o = observe(which, 1'b0);
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: got {busy,done,e,w,r,wv,row,col}=%b required %b",
                         name, k, o, e);
            end
        end
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        vec_t o;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 1; w <= 2; w++) begin
            o = observe(w, 1'b1);
            n_vec++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got %b required %b", w, o, vec_t'('0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        run_frames(1, 2, FRAME, 1'b0, "frame_rbs2");
        run_frames(1, 2, FRAME, 1'b0, "frame_rbs2_again");
    endtask

    task automatic test_start_held();
        run_frames(1, 2, 2 * FRAME, 1'b1, "start_held");
    endtask

    task automatic test_reset_midframe();
        vec_t o;
        run_frames(1, 2, 20, 1'b0, "pre_reset");
        rst_n = 1'b0;
        #1;
        o = observe(1, 1'b1);
        n_vec++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL reset_midframe: got %b required %b", o, vec_t'('0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(1, 2, FRAME, 1'b0, "after_reset");
    endtask

    task automatic test_all_rows_buffered();
        run_frames(2, 4, FRAME, 1'b0, "frame_rbs4");
    endtask

`ifdef RB_CTRL_ABORT_EN
    task automatic test_abort();
        vec_t o;
        run_frames(1, 2, 25, 1'b0, "pre_abort");
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        o = observe(1, 1'b1);
        n_vec++;
        if (o !== '0) begin
            n_err++;
            $display("FAIL abort_idle: got %b required %b", o, vec_t'('0));
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            o = observe(1, 1'b1);
            n_vec++;
            if (o !== '0) begin
                n_err++;
                $display("FAIL abort_quiet cycle %0d: got %b required %b", k, o, vec_t'('0));
            end
        end
        run_frames(1, 2, FRAME, 1'b0, "after_abort");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame();
        test_start_held();
        test_reset_midframe();
        test_all_rows_buffered();
`ifdef RB_CTRL_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
